// File: rtl/reg_wb_pkg.sv
// Shared constants and types for the register-file writeback sequencer.
// XLEN and AW are fixed here; the load-return buffer depth is a parameter of
// reg_wb_scoreboard and wb_fifo (default LBUF_DEPTH_DEF).
package reg_wb_pkg;

    localparam int XLEN           = 32;
    localparam int AW             = 5;
    localparam int NREG           = 1 << AW;
    localparam int LBUF_DEPTH_DEF = 2;

    // One pending register-file write: destination index plus data.
    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // A register is pending only if its scoreboard bit is set; x0 never is.
    function automatic logic idx_busy(input logic [NREG-1:0] vec, input logic [AW-1:0] idx);
        return (idx != '0) && vec[idx];
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of wb_req_t holding load returns that could not write the
// register file in the cycle they arrived. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = LBUF_DEPTH_DEF
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    enq,
    input  wb_req_t enq_req,
    input  logic    deq,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    wb_req_t     mem_q [DEPTH];
    wb_req_t     mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head  = mem_q[rd_ptr_q[PW-1:0]];

    // Next pointers and storage; requests against full/empty are ignored.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (enq && !full) begin
            mem_d[wr_ptr_q[PW-1:0]] = enq_req;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (deq && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // State registers; reset empties the buffer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/reg_wb_scoreboard.sv
// Writeback sequencer for the single register-file write port.
// Arbitrates ALU writeback against load returns (buffered in wb_fifo), keeps a
// load-pending scoreboard and stalls decode on RAW/WAW hazards against it.
// Optional feature macro: WB_FWD_EN adds fwd_a_hit/fwd_b_hit/fwd_data so a
// source committing this cycle is forwarded instead of stalling.
//
// Load-return handshake: a return transfers on a cycle where mem_wb_valid and
// mem_wb_ready are both high; while ready is low the producer holds rd/data
// stable. ready depends only on registered buffer state.
module reg_wb_scoreboard
    import reg_wb_pkg::*;
#(
    parameter int LBUF_DEPTH = LBUF_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_is_load,
    output logic            id_stall,
    input  logic            alu_wb_valid,
    input  logic [AW-1:0]   alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    input  logic            mem_wb_valid,
    input  logic [AW-1:0]   mem_wb_rd,
    input  logic [XLEN-1:0] mem_wb_data,
    output logic            mem_wb_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] busy_vec
`ifdef WB_FWD_EN
    ,
    output logic            fwd_a_hit,
    output logic            fwd_b_hit,
    output logic [XLEN-1:0] fwd_data
`endif
);

    logic [NREG-1:0] busy_q, busy_d;

    wb_req_t head_req;
    wb_req_t sel_req;
    logic    fifo_full, fifo_empty;
    logic    fifo_enq, fifo_deq;
    logic    mem_accept;
    logic    mem_bypass;
    logic    sel_valid;
    logic    commit_valid;
    logic    issue;
    logic    rs1_block, rs2_block, rd_block;
    logic    fwd_a, fwd_b;

    wb_fifo #(
        .DEPTH (LBUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .enq     (fifo_enq),
        .enq_req ('{rd: mem_wb_rd, data: mem_wb_data}),
        .deq     (fifo_deq),
        .head    (head_req),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign mem_wb_ready = !fifo_full;
    assign mem_accept   = mem_wb_valid && !fifo_full;
    assign busy_vec     = busy_q;

    // Write-port priority: ALU, then buffer head, then direct load bypass.
    // A committed load with rd==0 is still consumed, just not written.
    always_comb begin
        sel_valid    = 1'b0;
        sel_req      = '{rd: alu_wb_rd, data: alu_wb_data};
        fifo_deq     = 1'b0;
        mem_bypass   = 1'b0;
        commit_valid = 1'b0;
        if (alu_wb_valid) begin
            sel_valid = 1'b1;
        end else if (!fifo_empty) begin
            sel_valid    = 1'b1;
            sel_req      = head_req;
            fifo_deq     = 1'b1;
            commit_valid = 1'b1;
        end else if (mem_accept) begin
            sel_valid    = 1'b1;
            sel_req      = '{rd: mem_wb_rd, data: mem_wb_data};
            mem_bypass   = 1'b1;
            commit_valid = 1'b1;
        end
        fifo_enq = mem_accept && !mem_bypass;
        rf_we    = sel_valid && (sel_req.rd != '0);
        rf_rd    = sel_req.rd;
        rf_wdata = sel_req.data;
    end

    // Hazard check against registered busy bits, with optional same-cycle forwarding.
    always_comb begin
`ifdef WB_FWD_EN
        fwd_a = id_valid && commit_valid && idx_busy(busy_q, id_rs1) && (sel_req.rd == id_rs1);
        fwd_b = id_valid && commit_valid && idx_busy(busy_q, id_rs2) && (sel_req.rd == id_rs2);
`else
        fwd_a = 1'b0;
        fwd_b = 1'b0;
`endif
        rs1_block = idx_busy(busy_q, id_rs1) && !fwd_a;
        rs2_block = idx_busy(busy_q, id_rs2) && !fwd_b;
        rd_block  = idx_busy(busy_q, id_rd);
        id_stall  = id_valid && (rs1_block || rs2_block || rd_block);
        issue     = id_valid && id_is_load && !id_stall && (id_rd != '0);
    end

`ifdef WB_FWD_EN
    assign fwd_a_hit = fwd_a;
    assign fwd_b_hit = fwd_b;
    assign fwd_data  = sel_req.data;
`endif

    // Scoreboard update: commit clears, issue sets, set wins on the same index.
    always_comb begin
        busy_d = busy_q;
        if (commit_valid) begin
            busy_d[sel_req.rd] = 1'b0;
        end
        if (issue) begin
            busy_d[id_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register; reset discards all in-flight loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule
